// File: rtl/avr_io_in.sv
// 8-bit AVR IO-bus input port: pin synchroniser, per-bit edge flags (W1C), maskable irq.
// Optional per-bit debounce filter enabled by defining AVR_IO_IN_DEBOUNCE_EN.
module avr_io_in #(
    parameter logic [7:0] PIN_RESET       = 8'h00,
    parameter int         DEBOUNCE_CYCLES = 15,
    parameter int         DEBOUNCE_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_re,
    input  logic       io_we,
    input  logic [1:0] io_a,
    output logic [7:0] io_di,
    input  logic [7:0] io_do,
    input  logic [7:0] pins,
    output logic       irq
);
    localparam logic [1:0] A_PIN  = 2'd0;
    localparam logic [1:0] A_IFR  = 2'd1;
    localparam logic [1:0] A_IMSK = 2'd2;
    localparam logic [1:0] A_ECTL = 2'd3;

    if (!((1 << DEBOUNCE_W) > DEBOUNCE_CYCLES)) begin : g_bad_cfg
        $error("DEBOUNCE_W too narrow for DEBOUNCE_CYCLES");
    end

    logic [7:0] s1_q, s2_q;
    logic [7:0] pin_q, pin_d;
    logic [7:0] ifr_q, ifr_d;
    logic [7:0] imsk_q, imsk_d;
    logic [7:0] ectl_q, ectl_d;
    logic [7:0] rise, fall, edge_ev, w1c;

`ifdef AVR_IO_IN_DEBOUNCE_EN
    logic [DEBOUNCE_W-1:0] cnt_q [8];
    logic [DEBOUNCE_W-1:0] cnt_d [8];

    // A bit only moves once s2 has disagreed with pin_q for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        pin_d = pin_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != pin_q[i]) begin
                if (cnt_q[i] == DEBOUNCE_W'(DEBOUNCE_CYCLES - 1)) begin
                    pin_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`else
    always_comb begin
        pin_d = s2_q;
    end
`endif

    // Edges are judged on the value pin_q is about to load, so flags set on the same edge.
    always_comb begin
        rise    = pin_d & ~pin_q;
        fall    = ~pin_d & pin_q;
        edge_ev = (rise & {8{ectl_q[0]}}) | (fall & {8{ectl_q[1]}});
        w1c     = (io_we && io_a == A_IFR) ? io_do : 8'h00;
        ifr_d   = (ifr_q & ~w1c) | edge_ev;
        imsk_d  = (io_we && io_a == A_IMSK) ? io_do : imsk_q;
        ectl_d  = (io_we && io_a == A_ECTL) ? io_do : ectl_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= PIN_RESET;
            s2_q   <= PIN_RESET;
            pin_q  <= PIN_RESET;
            ifr_q  <= 8'h00;
            imsk_q <= 8'h00;
            ectl_q <= 8'h00;
        end else begin
            s1_q   <= pins;
            s2_q   <= s1_q;
            pin_q  <= pin_d;
            ifr_q  <= ifr_d;
            imsk_q <= imsk_d;
            ectl_q <= ectl_d;
        end
    end

    // Read mux returns zero when not selected so several ports can be OR-ed onto one bus.
    always_comb begin
        io_di = 8'h00;
        if (io_re) begin
            case (io_a)
                A_PIN:   io_di = pin_q;
                A_IFR:   io_di = ifr_q;
                A_IMSK:  io_di = imsk_q;
                A_ECTL:  io_di = ectl_q;
                default: io_di = 8'h00;
            endcase
        end
    end

    assign irq = |(ifr_q & imsk_q);

endmodule

// File: tb/tb_avr_io_in.sv
// Directed bench for avr_io_in: expected values queued with each step, popped at each check.
module tb_avr_io_in;
    logic       clk = 1'b0;
    logic       rst;
    logic       io_re, io_we;
    logic [1:0] io_a;
    logic [7:0] io_di, io_do, pins;
    logic       irq;

`ifdef AVR_IO_IN_DEBOUNCE_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 2;
`endif

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    avr_io_in dut (
        .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_a(io_a),
        .io_di(io_di), .io_do(io_do), .pins(pins), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed %h", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
        exp_q.push_back(exp);
        io_re = 1'b1;
        io_a  = a;
        #1;
        check(tag, io_di);
        io_re = 1'b0;
        io_a  = 2'd0;
    endtask

    task automatic irq_chk(input logic exp, input string tag);
        exp_q.push_back({7'b0, exp});
        check(tag, {7'b0, irq});
    endtask

    task automatic idle_chk(input string tag);
        exp_q.push_back(8'h00);
        check(tag, io_di);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        io_we = 1'b1;
        io_a  = a;
        io_do = d;
        @(posedge clk);
        #1;
        io_we = 1'b0;
        io_a  = 2'd0;
        io_do = 8'h00;
    endtask

    initial begin
        rst = 1'b0; io_re = 1'b0; io_we = 1'b0; io_a = 2'd0; io_do = 8'h00;
        pins = 8'hA5;
        step(3);

        // Reset and pin propagation
        rst = 1'b1;
        rd(2'd0, 8'h00, "pin_at_release");
        irq_chk(1'b0, "irq_reset");
        step(LAT);
        rd(2'd0, 8'h00, "pin_before_lat");
        step(1);
        rd(2'd0, 8'hA5, "pin_after_lat");
        rd(2'd1, 8'h00, "ifr_reset");
        rd(2'd2, 8'h00, "imsk_reset");
        rd(2'd3, 8'h00, "ectl_reset");

        // Rising edges only
        wr(2'd3, 8'h01);
        wr(2'd2, 8'h01);
        rd(2'd3, 8'h01, "ectl_wr");
        pins = 8'h00;
        step(LAT + 2);
        rd(2'd1, 8'h00, "ifr_no_fall_flag");
        pins = 8'h01;
        step(LAT);
        rd(2'd1, 8'h00, "ifr_rise_early");
        irq_chk(1'b0, "irq_rise_early");
        step(1);
        rd(2'd1, 8'h01, "ifr_rise");
        irq_chk(1'b1, "irq_rise");
        wr(2'd0, 8'hFF);
        rd(2'd0, 8'h01, "pin_ro");
        pins = 8'h00;
        step(LAT + 2);
        rd(2'd1, 8'h01, "ifr_fall_ignored");

        // W1C and set-wins race
        pins = 8'h02;
        step(LAT + 2);
        rd(2'd1, 8'h03, "ifr_two_flags");
        wr(2'd1, 8'h01);
        rd(2'd1, 8'h02, "ifr_w1c");
        wr(2'd1, 8'h00);
        rd(2'd1, 8'h02, "ifr_w0_nop");
        pins = 8'h00;
        step(LAT + 2);
        wr(2'd1, 8'h02);
        rd(2'd1, 8'h00, "ifr_cleared");
        pins = 8'h02;
        step(LAT);
        wr(2'd1, 8'h02);
        rd(2'd1, 8'h02, "ifr_set_wins");

        // Masking
        wr(2'd2, 8'h00);
        wr(2'd1, 8'hFF);
        pins = 8'h82;
        step(LAT + 2);
        rd(2'd1, 8'h80, "ifr_bit7");
        irq_chk(1'b0, "irq_masked");
        wr(2'd2, 8'h80);
        irq_chk(1'b1, "irq_unmasked");
        wr(2'd1, 8'h80);
        irq_chk(1'b0, "irq_after_clear");

        // Both edges, bus idle
        wr(2'd3, 8'hAF);
        rd(2'd3, 8'hAF, "ectl_scratch");
        wr(2'd3, 8'h03);
        pins = 8'h8A;
        step(LAT + 2);
        idle_chk("idle_a");
        rd(2'd1, 8'h08, "ifr_both_rise");
        wr(2'd1, 8'h08);
        pins = 8'h82;
        step(2);
        idle_chk("idle_b");
        step(LAT);
        rd(2'd1, 8'h08, "ifr_both_fall");
        wr(2'd1, 8'h08);
        idle_chk("idle_c");
        rd(2'd1, 8'h00, "ifr_both_cleared");

`ifdef AVR_IO_IN_DEBOUNCE_EN
        // Debounce: short glitch filtered, long pulse accepted
        wr(2'd3, 8'h01);
        pins = 8'h83;
        step(10);
        pins = 8'h82;
        step(24);
        rd(2'd0, 8'h82, "pin_glitch");
        rd(2'd1, 8'h00, "ifr_glitch");
        pins = 8'h83;
        step(LAT);
        rd(2'd0, 8'h82, "pin_db_early");
        step(1);
        rd(2'd0, 8'h83, "pin_db");
        rd(2'd1, 8'h01, "ifr_db");
`endif

        // Reset mid-operation drops pending flags
        pins = 8'h83;
        wr(2'd3, 8'h03);
        pins = 8'h82;
        step(LAT + 2);
        rst = 1'b0;
        #1;
        rd(2'd1, 8'h00, "ifr_async_reset");
        irq_chk(1'b0, "irq_async_reset");
        step(2);
        rst = 1'b1;
        step(LAT + 2);
        rd(2'd0, 8'h82, "pin_after_rerelease");
        rd(2'd1, 8'h00, "ifr_after_rerelease");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/avr_io_in.md
Name: avr_io_in

Overview:
- 8-bit general-purpose input port on the AVR IO bus; the read-side counterpart of the output port peripheral.
- Synchronises external pins and detects edges per bit.
- Latches edge events into write-1-to-clear flags and raises a maskable interrupt into the core's priority encoder.
- Occupies one 4-register window, selected by the top-level io_a decode.

Parameters:
- PIN_RESET, 8'h00, value loaded into the synchroniser and filtered-pin registers at reset.
- DEBOUNCE_CYCLES, 15, consecutive stable cycles required before a filtered bit changes. Used only with AVR_IO_IN_DEBOUNCE_EN.
- DEBOUNCE_W, 4, per-bit debounce counter width. Must satisfy 2^DEBOUNCE_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting (low) clears state immediately; release is synchronous to clk.
- io_re  input  1  IO read strobe, pre-qualified by the top-level select.
- io_we  input  1  IO write strobe, pre-qualified by the top-level select.
- io_a  input  2  register address within the window.
- io_di  output  8  read data to the core.
- io_do  input  8  write data from the core.
- pins  input  8  asynchronous external inputs.
- irq  output  1  interrupt request, level-sensitive.

Behaviour:
- Register map (io_a):
  - 0 PIN: read-only filtered pin value. Writes are ignored.
  - 1 IFR: edge flags. Read returns the flags. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - 2 IMSK: interrupt mask, read/write.
  - 3 ECTL: read/write. Bits [1:0] select the edge mode: 00 none, 01 rising, 10 falling, 11 both. Bits [7:2] are read/write scratch.
- Reads:
  - io_di is combinational: the addressed register whenever io_re=1, else 8'h00 (OR-able bus).
  - Zero wait states. A read has no side effects; reading IFR does not clear it.
- Writes: take effect at the clk edge where io_we=1. The register shows the new value from the next cycle.
- Synchroniser: two flops per bit (s1, s2), reset to PIN_RESET.
- Filtered pin register pin_q, reset to PIN_RESET. Without debounce, pin_q <= s2 every cycle.
- Edge detect, per bit, combinational:
  - rise = s2 & ~pin_q when pin_q is about to load 1.
  - fall = ~s2 & pin_q when pin_q is about to load 0.
  - Qualified by ECTL[1:0]. Flag set occurs on the same edge that pin_q updates.
- Latency without debounce: a pin change captured into s1 at edge N gives pin_q and the IFR bit updated at edge N+2, and irq high after edge N+2.
- Simultaneous edge event and W1C on the same IFR bit in the same cycle: set wins and the flag stays 1.
- irq = |(IFR & IMSK), combinational from registers, no extra delay.
  - Changing IMSK or clearing IFR affects irq in the next cycle.
  - Pending flags assert irq when unmasked.
- A write to ECTL does not retroactively set flags; only subsequent pin_q changes are evaluated under the new mode.
- Reset values:
  - s1, s2, pin_q = PIN_RESET.
  - IFR = 8'h00, IMSK = 8'h00, ECTL = 8'h00.
  - irq = 0, io_di = 8'h00.
  - Reset mid-operation discards pending flags and debounce counts. No edge is reported for pins that differ from PIN_RESET at release until pin_q actually changes.

Optional Feature:
- Macro AVR_IO_IN_DEBOUNCE_EN.
- Defined: each bit has a DEBOUNCE_W-bit counter, reset 0.
  - While s2==pin_q the counter is held at 0.
  - While s2!=pin_q it increments; when it reaches DEBOUNCE_CYCLES-1 and s2 still differs, pin_q toggles to s2 and the counter returns to 0.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pin_q change and no flag.
  - Latency from s1 capture to pin_q becomes 1+DEBOUNCE_CYCLES edges.
- Undefined: no counters; pin_q follows s2 with the single-register latency stated above.

Test Plan:
- Reset: hold rst=0, pins=8'hA5. Release and read all four addresses -> PIN=8'h00 before the pins propagate, then 8'hA5 about 3 cycles later. IFR=IMSK=ECTL=8'h00, irq=0.
- Rising edges: ECTL=8'h01, IMSK=8'h01. Drive pins 8'h00->8'h01 -> IFR=8'h01 and irq=1 within 3 edges. Drive pins 8'h01->8'h00 -> IFR unchanged.
- W1C and race: IFR=8'h03; write IFR=8'h01 -> IFR=8'h02. Write IFR=8'h02 in the same cycle as a new bit-1 edge -> IFR bit1 stays 1.
- Masking: with IFR=8'h80 and IMSK=8'h00, irq=0. Write IMSK=8'h80 -> irq=1 the next cycle. Write IFR=8'h80 -> irq=0.
- Both edges, bus idle: ECTL=8'h03; toggle pins[3] twice with clears in between -> IFR=8'h08 each time. With io_re=0, io_di=8'h00 throughout.
- Debounce (macro defined, DEBOUNCE_CYCLES=15):
  - A 10-cycle high pulse on pins[0] -> PIN bit0 stays 0 and there is no flag.
  - A 20-cycle pulse -> PIN bit0 goes 1 at s1-capture + 16 edges and IFR bit0 sets (ECTL=01).
